// File: rtl/spoc_pkg.sv
// Shared constants and types for the SpoC-64 Simeck-box datapath.
package spoc_pkg;

    localparam int SB_WIDTH = 48;
    localparam int SB_RNDS  = 6;
    localparam int ROT_A    = 5;
    localparam int ROT_B    = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sb_state_e;

endpackage

// File: rtl/sb_inv_step.sv
// One inverse Simeck-box round: {A',B'} -> {B', A'^f(B')^C}.
module sb_inv_step
    import spoc_pkg::*;
#(
    parameter int WIDTH = SB_WIDTH
) (
    input  logic [WIDTH-1:0] st,
    input  logic             rc_bit,
    output logic [WIDTH-1:0] nxt
);

    localparam int H = WIDTH / 2;

    logic [H-1:0] a;
    logic [H-1:0] b;
    logic [H-1:0] rot_a;
    logic [H-1:0] rot_b;
    logic [H-1:0] fb;
    logic [H-1:0] c;

    assign a     = st[WIDTH-1:H];
    assign b     = st[H-1:0];
    assign rot_a = (b << ROT_A) | (b >> (H - ROT_A));
    assign rot_b = (b << ROT_B) | (b >> (H - ROT_B));
    assign fb    = (rot_a & b) ^ rot_b;
    assign c     = {{(H-1){1'b1}}, rc_bit};
    assign nxt   = {b, a ^ fb ^ c};

endmodule

// File: rtl/sb_inv.sv
// Iterative inverse of the SB Feistel permutation, one round per clock.
module sb_inv
    import spoc_pkg::*;
#(
    parameter int WIDTH   = SB_WIDTH,
    parameter int NUM_RND = SB_RNDS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] sin,
    input  logic [7:0]       rc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sout,
    output logic             busy
);

    localparam int CW = (NUM_RND > 1) ? $clog2(NUM_RND) : 1;

    sb_state_e        st;
    logic [WIDTH-1:0] state_reg;
    logic [WIDTH-1:0] step_out;
    logic [7:0]       rc_reg;
    logic [CW-1:0]    ctr;

    // rc is left-aligned on capture so bit 7 is always the constant for
    // the current step; rc[NUM_RND-1] is applied first, rc[0] last.
    sb_inv_step #(.WIDTH(WIDTH)) u_step (
        .st     (state_reg),
        .rc_bit (rc_reg[7]),
        .nxt    (step_out)
    );

    assign in_ready = rst && (st == IDLE);
    assign sout     = state_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st        <= IDLE;
            state_reg <= '0;
            rc_reg    <= '0;
            ctr       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (st)
                IDLE: begin
                    if (in_valid) begin
                        state_reg <= sin;
                        rc_reg    <= rc << (8 - NUM_RND);
                        ctr       <= CW'(NUM_RND - 1);
                        busy      <= 1'b1;
                        st        <= RUN;
                    end
                end
                RUN: begin
                    state_reg <= step_out;
                    rc_reg    <= {rc_reg[6:0], 1'b0};
                    if (ctr == '0) begin
                        out_valid <= 1'b1;
                        st        <= DONE;
                    end else begin
                        ctr <= ctr - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        st        <= IDLE;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sb_inv.sv
// Directed + randomized bench for sb_inv against a behavioural SB model.
module tb_sb_inv;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [47:0] sin, sout;
    logic [7:0]  rc;
    logic        in_valid2, in_ready2, out_valid2, out_ready2, busy2;
    logic [47:0] sin2, sout2;
    logic [7:0]  rc2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sb_inv dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .sin(sin), .rc(rc),
        .out_valid(out_valid), .out_ready(out_ready),
        .sout(sout), .busy(busy)
    );

    sb_inv #(.WIDTH(48), .NUM_RND(2)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .sin(sin2), .rc(rc2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .sout(sout2), .busy(busy2)
    );

    function automatic logic [23:0] rotl(input logic [23:0] x, input int r);
        return (x << r) | (x >> (24 - r));
    endfunction

    function automatic logic [23:0] f(input logic [23:0] x);
        return (rotl(x, 5) & x) ^ rotl(x, 1);
    endfunction

    function automatic logic [23:0] cst(input logic [7:0] r, input int i);
        return {23'h7FFFFF, r[i]};
    endfunction

    function automatic logic [47:0] fwd(input logic [47:0] x,
                                        input logic [7:0] r, input int n);
        logic [23:0] a, b, t;
        a = x[47:24];
        b = x[23:0];
        for (int i = 0; i < n; i++) begin
            t = f(a) ^ b ^ cst(r, i);
            b = a;
            a = t;
        end
        return {a, b};
    endfunction

    function automatic logic [47:0] inv(input logic [47:0] x,
                                        input logic [7:0] r, input int n);
        logic [23:0] a, b, t;
        a = x[47:24];
        b = x[23:0];
        for (int i = n - 1; i >= 0; i--) begin
            t = a ^ f(b) ^ cst(r, i);
            a = b;
            b = t;
        end
        return {a, b};
    endfunction

    task automatic chk(input string tag, input logic [47:0] obs,
                       input logic [47:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Accept one input, then count edges until out_valid (bounded).
    task automatic run_txn(input logic [47:0] x, input logic [7:0] r,
                           output logic [47:0] res, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        in_valid = 1'b1;
        sin      = x;
        rc       = r;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        res = sout;
    endtask

    task automatic pop;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [47:0] x, y, res, held, r00;
        logic [7:0]  r;
        int          lat;

        rst = 1'b0;
        in_valid = 0; out_ready = 0; sin = '0; rc = '0;
        in_valid2 = 0; out_ready2 = 0; sin2 = '0; rc2 = '0;
        repeat (3) tick();
        chk("rst_sout", sout, 48'h0);
        chk("rst_oval", {47'h0, out_valid}, 48'h0);
        chk("rst_busy", {47'h0, busy}, 48'h0);
        rst = 1'b1;
        #1;
        chk("rst_inrdy", {47'h0, in_ready}, 48'h1);

        // zero vector, two rounds
        in_valid2 = 1'b1;
        tick();
        in_valid2 = 1'b0;
        repeat (2) tick();
        chk("zero_oval", {47'h0, out_valid2}, 48'h1);
        chk("zero_sout", sout2, 48'hFFFFFE_FFFFDD);
        chk("zero_model", sout2, inv(48'h0, 8'h00, 2));
        out_ready2 = 1'b1;
        tick();
        out_ready2 = 1'b0;

        // random round trip through the forward model
        for (int k = 0; k < 200; k++) begin
            x = {16'($urandom), 32'($urandom)};
            r = 8'($urandom);
            run_txn(fwd(x, r, 6), r, res, lat);
            chk("rt_lat", 48'(lat), 48'd6);
            chk("rt_sout", res, x);
            pop();
        end

        // backpressure
        x = {16'($urandom), 32'($urandom)};
        r = 8'($urandom);
        run_txn(x, r, held, lat);
        chk("bp_first", held, inv(x, r, 6));
        for (int k = 0; k < 10; k++) begin
            in_valid = k[0];
            sin = ~x;
            tick();
            chk("bp_sout", sout, held);
            chk("bp_oval", {47'h0, out_valid}, 48'h1);
            chk("bp_inrdy", {47'h0, in_ready}, 48'h0);
        end
        in_valid = 1'b0;
        pop();
        chk("bp_rel_inrdy", {47'h0, in_ready}, 48'h1);
        chk("bp_rel_oval", {47'h0, out_valid}, 48'h0);

        // simultaneous out_ready and in_valid in DONE
        x = {16'($urandom), 32'($urandom)};
        y = {16'($urandom), 32'($urandom)};
        r = 8'($urandom);
        run_txn(x, r, res, lat);
        chk("sim_first", res, inv(x, r, 6));
        out_ready = 1'b1;
        in_valid  = 1'b1;
        sin       = y;
        rc        = ~r;
        tick();
        out_ready = 1'b0;
        chk("sim_busy", {47'h0, busy}, 48'h0);
        chk("sim_inrdy", {47'h0, in_ready}, 48'h1);
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("sim_lat", 48'(lat), 48'd6);
        chk("sim_second", sout, inv(y, ~r, 6));
        pop();

        // reset in the middle of RUN
        in_valid = 1'b1;
        sin = {16'($urandom), 32'($urandom)};
        rc = 8'hA5;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("mrst_sout", sout, 48'h0);
        chk("mrst_oval", {47'h0, out_valid}, 48'h0);
        chk("mrst_busy", {47'h0, busy}, 48'h0);
        tick();
        rst = 1'b1;
        #1;
        chk("mrst_inrdy", {47'h0, in_ready}, 48'h1);
        run_txn(48'h123456_789ABC, 8'h2A, res, lat);
        chk("mrst_lat", 48'(lat), 48'd6);
        chk("mrst_fresh", res, inv(48'h123456_789ABC, 8'h2A, 6));
        pop();

        // constant order: rc[0] only touches the low half's bit 0
        x = {16'($urandom), 32'($urandom)};
        r00 = inv(x, 8'h00, 6);
        run_txn(x, 8'h01, res, lat);
        chk("ord_01", res, inv(x, 8'h01, 6));
        chk("ord_01_diff", res ^ r00, 48'h1);
        pop();
        run_txn(x, 8'h20, res, lat);
        chk("ord_20", res, inv(x, 8'h20, 6));
        chk("ord_20_diff", res ^ r00, inv(x, 8'h20, 6) ^ r00);
        chk("ord_20_hi", {47'h0, (res[47:24] != r00[47:24])}, 48'h1);
        pop();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
